// File: rtl/wb_uart_tx_peripheral.sv
// Wishbone classic slave UART transmitter: byte FIFO feeding a baud-timed 8N1 serialiser.
// state | meaning
// IDLE  | line high; pops the next byte when the FIFO is non-empty
// START | start bit (low) for one bit period
// DATA  | 8 data bits, LSB first, one bit period each
// STOP  | stop bit (high) for one bit period
module wb_uart_tx_peripheral #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              tx_o,
  output logic              tx_busy_o,
  output logic              fifo_empty_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;

  logic        req, wr_en, stall, push, pop, full, empty, busy, tick, tx;
  logic [1:0]  reg_sel;
  logic [15:0] period_m1;
  logic [31:0] cnt_ext, rdata;
  logic        unused_bits;

  assign reg_sel     = wb_adr_i[3:2];
  assign req         = wb_cyc_i & wb_stb_i & ~ack_q;
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign busy        = (state_q != IDLE);
  assign wr_en       = req & wb_we_i & wb_sel_i[0];
  // A TX_DATA write against a full FIFO is held off until a pop frees a slot.
  assign stall       = wr_en & (reg_sel == 2'd0) & full;
  assign push        = wr_en & (reg_sel == 2'd0) & ~full;
  assign pop         = (state_q == IDLE) & ~empty;
  assign ack_d       = req & ~stall;
  assign baud_d      = (wr_en && reg_sel == 2'd2) ? wb_dat_i[15:0] : baud_q;
  assign cnt_ext     = 32'(count_q);
  assign unused_bits = ^{wb_dat_i[31:16], wb_sel_i[3:1], wb_adr_i[1:0]};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd1:    rdata = {20'b0, cnt_ext[3:0], 5'b0, busy, empty, full};
      2'd2:    rdata = {16'b0, baud_q};
      default: rdata = '0;
    endcase
  end

  assign dat_d = (req && !wb_we_i) ? rdata : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      baud_q   <= DEFAULT_DIV;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      baud_q <= baud_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wb_dat_i[7:0];
  end

  // Bit timer reloads from the live divisor at each bit boundary.
  assign period_m1 = (baud_q == 16'd0) ? 16'd0 : baud_q - 16'd1;
  assign tick      = (tmr_q == 16'd0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx      = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          shift_d = mem_q[rd_ptr_q];
          tmr_d   = period_m1;
          state_d = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) begin
          tmr_d   = period_m1;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (tick) begin
          tmr_d   = period_m1;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          tmr_d = tmr_q - 16'd1;
        end
      end
      STOP: begin
        if (tick) state_d = IDLE;
        else      tmr_d   = tmr_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Line level is decoded from async-reset state, so reset forces it high at once.
  assign tx_o         = tx;
  assign tx_busy_o    = busy;
  assign fifo_empty_o = empty;
  assign wb_ack_o     = ack_q;
  assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_wb_uart_tx_peripheral.sv
// Directed bench for wb_uart_tx_peripheral: register table, frame capture on tx_o, FIFO stall and reset cases.
module tb_wb_uart_tx_peripheral;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  adr = '0, sel = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack, tx, busy, empty;

  always #5 clk_i = ~clk_i;

  wb_uart_tx_peripheral #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd868), .ADDR_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .tx_o(tx), .tx_busy_o(busy), .fifo_empty_o(empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Line monitor: samples tx on every falling clock edge and records complete frames.
  typedef struct { logic [7:0] d; bit ok; int s; int e; } frame_t;
  frame_t     frames[$];
  int         cyc_n = 0, busy_cnt = 0, mon_period = 4;
  bit         mon_active = 0, mon_ok;
  int         mon_idx, mon_start, bit_no, pos;
  logic       mon_lvl;
  logic [7:0] mon_byte;

  initial begin
    forever begin
      @(negedge clk_i);
      cyc_n++;
      if (busy) busy_cnt++;
      if (!rst_i) begin
        mon_active = 0;
      end else begin
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1; mon_idx = 0; mon_ok = 1; mon_byte = '0; mon_start = cyc_n;
        end
        if (mon_active) begin
          bit_no = mon_idx / mon_period;
          pos    = mon_idx % mon_period;
          if (pos == 0) begin
            mon_lvl = tx;
            if (bit_no >= 1 && bit_no <= 8) mon_byte[bit_no-1] = tx;
            if (bit_no == 9 && tx !== 1'b1) mon_ok = 0;
          end else if (tx !== mon_lvl) begin
            mon_ok = 0;
          end
          mon_idx++;
          if (mon_idx == 10 * mon_period) begin
            frame_t f;
            f.d = mon_byte; f.ok = mon_ok; f.s = mon_start; f.e = cyc_n;
            frames.push_back(f);
            mon_active = 0;
          end
        end
      end
    end
  end

  // Caller is positioned just after a rising edge; returns lat=0 if no ack within budget.
  task automatic wb_access(input logic w, input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int budget,
                           output logic [31:0] rd, output int lat);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    lat = 0; rd = '0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk_i); #1;
      if (ack) begin lat = i; rd = dat_o; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input string name);
    logic [31:0] rd; int lat;
    wb_access(1'b1, a, d, 4'hF, 20, rd, lat);
    check({name, " ack latency"}, lat, 1);
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    for (int i = 0; i < budget && frames.size() < n; i++) begin
      @(posedge clk_i); #1;
    end
    check({name, " frame count"}, frames.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  typedef struct {
    string name; logic w; logic [3:0] a; logic [31:0] d; logic [3:0] s; bit chk; logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  logic [31:0] rd;
  int          lat, acks;

  initial begin
    vecs[0]  = '{"rd STATUS reset",   1'b0, 4'h4, 32'h0,         4'hF, 1, 32'h0000_0002};
    vecs[1]  = '{"rd BAUD reset",     1'b0, 4'h8, 32'h0,         4'hF, 1, 32'd868};
    vecs[2]  = '{"wr BAUD",           1'b1, 4'h8, 32'hABCD_1234, 4'hF, 0, 32'h0};
    vecs[3]  = '{"rd BAUD upper 0",   1'b0, 4'h8, 32'h0,         4'hF, 1, 32'h0000_1234};
    vecs[4]  = '{"wr BAUD no sel0",   1'b1, 4'h8, 32'h7,         4'hE, 0, 32'h0};
    vecs[5]  = '{"rd BAUD kept",      1'b0, 4'h8, 32'h0,         4'hF, 1, 32'h0000_1234};
    vecs[6]  = '{"wr reserved",       1'b1, 4'hC, 32'h55,        4'hF, 0, 32'h0};
    vecs[7]  = '{"rd reserved",       1'b0, 4'hC, 32'h0,         4'hF, 1, 32'h0};
    vecs[8]  = '{"rd BAUD after rsv", 1'b0, 4'h8, 32'h0,         4'hF, 1, 32'h0000_1234};
    vecs[9]  = '{"rd TX_DATA",        1'b0, 4'h0, 32'h0,         4'hF, 1, 32'h0};
    vecs[10] = '{"wr TX sel 1110",    1'b1, 4'h0, 32'h77,        4'hE, 0, 32'h0};
    vecs[11] = '{"rd STATUS no push", 1'b0, 4'h4, 32'h0,         4'hF, 1, 32'h0000_0002};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    check("reset tx", tx, 1); check("reset busy", busy, 0); check("reset empty", empty, 1);
    check("reset ack", ack, 0); check("reset dat_o", dat_o, 0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;

    // Register map table
    for (int i = 0; i < 12; i++) begin
      wb_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, 20, rd, lat);
      check({vecs[i].name, " latency"}, lat, 1);
      if (vecs[i].chk) check({vecs[i].name, " data"}, rd, vecs[i].exp);
    end
    check("no frame from sel1110", frames.size(), 0);

    // Held strobe: ack pulses 1,0,1,0 and dat_o is 0 between acks
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'h4; sel = 4'hF;
    @(posedge clk_i); #1; check("held stb ack1", ack, 1); check("held stb data", dat_o, 32'h2);
    @(posedge clk_i); #1; check("held stb ack2", ack, 0); check("dat_o idle 0", dat_o, 0);
    @(posedge clk_i); #1; check("held stb ack3", ack, 1);
    @(posedge clk_i); #1; check("held stb ack4", ack, 0);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk_i); #1;

    // DIV=4, 0x55
    wr(4'h8, 32'd4, "baud4");
    mon_period = 4; frames.delete(); busy_cnt = 0;
    wr(4'h0, 32'h55, "tx 55");
    wait_frames(1, 200, "0x55");
    wait_idle(50);
    if (frames.size() >= 1) begin
      check("0x55 data", frames[0].d, 8'h55);
      check("0x55 bit widths", frames[0].ok, 1);
    end
    check("0x55 busy cycles", busy_cnt, 40);

    // DIV=2, back-to-back frames
    wr(4'h8, 32'd2, "baud2");
    mon_period = 2; frames.delete();
    wr(4'h0, 32'hA3, "tx A3");
    wr(4'h0, 32'h0F, "tx 0F");
    wait_frames(2, 200, "A3/0F");
    wait_idle(50);
    if (frames.size() >= 2) begin
      check("frame1 data", frames[0].d, 8'hA3);
      check("frame2 data", frames[1].d, 8'h0F);
      check("frame1 widths", frames[0].ok, 1);
      check("frame2 widths", frames[1].ok, 1);
      check_range("inter-frame gap", frames[1].s - frames[0].e, 1, 2);
    end

    // DIV=100: fill FIFO, abort a stalled write, then a write that stalls until a pop
    wr(4'h8, 32'd100, "baud100");
    mon_period = 100; frames.delete();
    for (int k = 1; k <= 9; k++) wr(4'h0, 32'(k), "fill");
    wb_access(1'b0, 4'h4, 32'h0, 4'hF, 20, rd, lat);
    check("STATUS full", rd, 32'h0000_0805);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h0; dat_i = 32'hEE; sel = 4'hF; acks = 0;
    repeat (5) begin @(posedge clk_i); #1; if (ack) acks++; end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk_i); #1;
    check("aborted write acks", acks, 0);
    wb_access(1'b1, 4'h0, 32'h0A, 4'hF, 3000, rd, lat);
    check_range("stalled write latency", lat, 800, 1100);
    wait_frames(10, 12000, "fifo order");
    wait_idle(300);
    for (int k = 0; k < 10 && k < frames.size(); k++) begin
      check("fifo order data", frames[k].d, 8'(k + 1));
      check("fifo order widths", frames[k].ok, 1);
    end

    // DIV=0 acts as 1 clock per bit
    wr(4'h8, 32'd0, "baud0");
    wb_access(1'b0, 4'h8, 32'h0, 4'hF, 20, rd, lat);
    check("BAUD reads 0", rd, 0);
    mon_period = 1; frames.delete(); busy_cnt = 0;
    wr(4'h0, 32'hFF, "tx FF");
    wait_frames(1, 100, "0xFF");
    wait_idle(50);
    if (frames.size() >= 1) begin
      check("0xFF data", frames[0].d, 8'hFF);
      check("0xFF widths", frames[0].ok, 1);
    end
    check("div0 busy cycles", busy_cnt, 10);

    // Reset mid-frame
    wr(4'h8, 32'd4, "baud4 again");
    mon_period = 4;
    wr(4'h0, 32'h00, "tx 00");
    repeat (10) @(posedge clk_i);
    #1;
    check("mid-frame tx low", tx, 0);
    #2 rst_i = 1'b0;
    #1;
    check("async reset tx", tx, 1);
    check("async reset busy", busy, 0);
    check("async reset empty", empty, 1);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    wb_access(1'b0, 4'h4, 32'h0, 4'hF, 20, rd, lat);
    check("post-reset STATUS", rd, 32'h0000_0002);
    wb_access(1'b0, 4'h8, 32'h0, 4'hF, 20, rd, lat);
    check("post-reset BAUD", rd, 32'd868);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
